// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter
//   Shares the single 32-bit frame-buffer BRAM port between three requesters,
//   in fixed priority order:
//     1. VGA scanout reads (fixed latency, fully pipelined)
//     2. the whole-buffer clear engine
//     3. draw-engine pixel writes, absorbed by a small write FIFO
//   Pixels are 8-bit bytes packed four per 32-bit word; pixel index bits [1:0]
//   select the byte lane.
//
// Ports
//   clk, reset          single clock, synchronous active-high reset
//   scan_*              scanout read request / returned pixel byte
//   draw_*              valid/ready pixel write channel into the FIFO
//   clear_*             clear start pulse, fill colour, busy flag
//   buffer_*            BRAM port (byte address, write data, read data,
//                       enable, reset tied low, byte write enables)
//   draw_stall_count    only with FB_ARB_STATS_EN: saturating count of cycles
//                       a draw was offered while the FIFO was full
//
// Build option
//   FB_ARB_STATS_EN     adds draw_stall_count and its counter.

module fb_port_arbiter #(
    parameter int PIXEL_ADDR_BITS = 17,
    parameter int NUM_PIXELS      = 120000,
    parameter int READ_LATENCY    = 1,
    parameter int WFIFO_DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic                       scan_req,
    input  logic [PIXEL_ADDR_BITS-1:0] scan_pixel_addr,
    output logic                       scan_rvalid,
    output logic [7:0]                 scan_rdata,

    input  logic                       draw_valid,
    output logic                       draw_ready,
    input  logic [PIXEL_ADDR_BITS-1:0] draw_pixel_addr,
    input  logic [7:0]                 draw_color,

    input  logic                       clear_start,
    input  logic [7:0]                 clear_color,
    output logic                       clear_busy,

    output logic [31:0]                buffer_addr,
    output logic [31:0]                buffer_din,
    input  logic [31:0]                buffer_dout,
    output logic                       buffer_en,
    output logic                       buffer_rst,
    output logic [3:0]                 buffer_we
`ifdef FB_ARB_STATS_EN
    ,
    output logic [15:0]                draw_stall_count
`endif
);

    localparam int WORD_BITS   = PIXEL_ADDR_BITS - 2;
    localparam int CLEAR_WORDS = (NUM_PIXELS + 3) / 4;
    localparam int PTR_BITS    = $clog2(WFIFO_DEPTH);

    localparam logic [WORD_BITS-1:0] LAST_WORD = WORD_BITS'(CLEAR_WORDS - 1);

    // Word index -> zero-extended byte address
    function automatic logic [31:0] word_to_byte(input logic [WORD_BITS-1:0] w);
        return {{(30 - WORD_BITS){1'b0}}, w, 2'b00};
    endfunction

    // ------------------------------------------------------------------
    // Grant decode
    // ------------------------------------------------------------------
    logic fifo_empty;
    logic fifo_full;
    logic gnt_scan;
    logic gnt_clear;
    logic gnt_draw;

    assign gnt_scan  = scan_req;
    assign gnt_clear = !scan_req && clear_busy;
    assign gnt_draw  = !scan_req && !clear_busy && !fifo_empty;

    // ------------------------------------------------------------------
    // Clear engine
    // ------------------------------------------------------------------
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

    clr_state_t           clr_state, clr_state_nxt;
    logic [WORD_BITS-1:0] clr_cnt,   clr_cnt_nxt;
    logic [7:0]           clr_color, clr_color_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            clr_state <= ST_IDLE;
            clr_cnt   <= '0;
            clr_color <= '0;
        end else begin
            clr_state <= clr_state_nxt;
            clr_cnt   <= clr_cnt_nxt;
            clr_color <= clr_color_nxt;
        end
    end

    always_comb begin
        clr_state_nxt = clr_state;
        clr_cnt_nxt   = clr_cnt;
        clr_color_nxt = clr_color;
        case (clr_state)
            ST_IDLE: begin
                if (clear_start) begin
                    clr_state_nxt = ST_CLEAR;
                    clr_cnt_nxt   = '0;
                    clr_color_nxt = clear_color;
                end
            end
            ST_CLEAR: begin
                // A scan cycle steals the port; the counter holds.
                if (!scan_req) begin
                    if (clr_cnt == LAST_WORD)
                        clr_state_nxt = ST_IDLE;
                    else
                        clr_cnt_nxt = clr_cnt + 1'b1;
                end
            end
            default: clr_state_nxt = ST_IDLE;
        endcase
    end

    assign clear_busy = (clr_state == ST_CLEAR);

    // ------------------------------------------------------------------
    // Draw write FIFO
    // ------------------------------------------------------------------
    logic [PIXEL_ADDR_BITS-1:0] fifo_addr  [WFIFO_DEPTH];
    logic [7:0]                 fifo_color [WFIFO_DEPTH];
    logic [PTR_BITS-1:0]        wr_ptr;
    logic [PTR_BITS-1:0]        rd_ptr;
    logic [PTR_BITS:0]          fifo_cnt;
    logic                       push;
    logic                       pop;

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == (PTR_BITS+1)'(WFIFO_DEPTH));
    // Held low during reset so nothing is accepted into a FIFO being flushed.
    assign draw_ready = !reset && !fifo_full;
    assign push       = draw_valid && draw_ready;
    assign pop        = gnt_draw;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                fifo_addr[wr_ptr]  <= draw_pixel_addr;
                fifo_color[wr_ptr] <= draw_color;
                wr_ptr             <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    logic [PIXEL_ADDR_BITS-1:0] head_addr;
    logic [7:0]                 head_color;

    assign head_addr  = fifo_addr[rd_ptr];
    assign head_color = fifo_color[rd_ptr];

    // ------------------------------------------------------------------
    // BRAM port mux
    // ------------------------------------------------------------------
    always_comb begin
        buffer_en   = 1'b0;
        buffer_we   = 4'h0;
        buffer_addr = 32'h0;
        buffer_din  = 32'h0;
        if (gnt_scan) begin
            buffer_en   = 1'b1;
            buffer_addr = word_to_byte(scan_pixel_addr[PIXEL_ADDR_BITS-1:2]);
        end else if (gnt_clear) begin
            buffer_en   = 1'b1;
            buffer_we   = 4'hF;
            buffer_addr = word_to_byte(clr_cnt);
            buffer_din  = {4{clr_color}};
        end else if (gnt_draw) begin
            buffer_en   = 1'b1;
            buffer_we   = 4'b0001 << head_addr[1:0];
            buffer_addr = word_to_byte(head_addr[PIXEL_ADDR_BITS-1:2]);
            buffer_din  = {4{head_color}};
        end
    end

    assign buffer_rst = 1'b0;

    // ------------------------------------------------------------------
    // Scan read tag pipeline: valid + byte lane follow the BRAM latency
    // ------------------------------------------------------------------
    logic [READ_LATENCY:1]      vld_pipe;
    logic [READ_LATENCY:1][1:0] lane_pipe;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe  <= '0;
            lane_pipe <= '0;
        end else begin
            vld_pipe[1]  <= scan_req;
            lane_pipe[1] <= scan_pixel_addr[1:0];
            for (int i = 2; i <= READ_LATENCY; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                lane_pipe[i] <= lane_pipe[i-1];
            end
        end
    end

    assign scan_rvalid = vld_pipe[READ_LATENCY];
    // Forced to zero when idle so the byte bus is quiet outside valid cycles.
    assign scan_rdata  = scan_rvalid ? buffer_dout[8*lane_pipe[READ_LATENCY] +: 8] : 8'h00;

    // ------------------------------------------------------------------
    // Optional stall statistics
    // ------------------------------------------------------------------
`ifdef FB_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset || clear_start)
            draw_stall_count <= '0;
        else if (draw_valid && !draw_ready && draw_stall_count != 16'hFFFF)
            draw_stall_count <= draw_stall_count + 1'b1;
    end
`endif

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed testbench for fb_port_arbiter with a behavioural 1-cycle BRAM.
// NUM_PIXELS is shrunk to 16 so a clear covers four words.
module tb_fb_port_arbiter;

    localparam int PAB = 17;

    logic            clk = 1'b0;
    logic            reset;
    logic            scan_req;
    logic [PAB-1:0]  scan_pixel_addr;
    logic            scan_rvalid;
    logic [7:0]      scan_rdata;
    logic            draw_valid;
    logic            draw_ready;
    logic [PAB-1:0]  draw_pixel_addr;
    logic [7:0]      draw_color;
    logic            clear_start;
    logic [7:0]      clear_color;
    logic            clear_busy;
    logic [31:0]     buffer_addr;
    logic [31:0]     buffer_din;
    logic [31:0]     buffer_dout;
    logic            buffer_en;
    logic            buffer_rst;
    logic [3:0]      buffer_we;
`ifdef FB_ARB_STATS_EN
    logic [15:0]     draw_stall_count;
`endif

    int total = 0;
    int bad   = 0;

    fb_port_arbiter #(
        .PIXEL_ADDR_BITS(PAB),
        .NUM_PIXELS     (16),
        .READ_LATENCY   (1),
        .WFIFO_DEPTH    (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .scan_req        (scan_req),
        .scan_pixel_addr (scan_pixel_addr),
        .scan_rvalid     (scan_rvalid),
        .scan_rdata      (scan_rdata),
        .draw_valid      (draw_valid),
        .draw_ready      (draw_ready),
        .draw_pixel_addr (draw_pixel_addr),
        .draw_color      (draw_color),
        .clear_start     (clear_start),
        .clear_color     (clear_color),
        .clear_busy      (clear_busy),
        .buffer_addr     (buffer_addr),
        .buffer_din      (buffer_din),
        .buffer_dout     (buffer_dout),
        .buffer_en       (buffer_en),
        .buffer_rst      (buffer_rst),
        .buffer_we       (buffer_we)
`ifdef FB_ARB_STATS_EN
        ,
        .draw_stall_count(draw_stall_count)
`endif
    );

    always #5 clk = ~clk;

    // BRAM model: read-before-write, one cycle latency, byte enables
    logic [31:0] mem [64];
    always @(posedge clk) begin
        if (buffer_en) begin
            buffer_dout <= mem[buffer_addr[7:2]];
            for (int b = 0; b < 4; b++)
                if (buffer_we[b]) mem[buffer_addr[7:2]][8*b +: 8] <= buffer_din[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic port_chk(input string tag, input logic en, input logic [3:0] we,
                            input logic [31:0] addr, input logic [31:0] din);
        chk({tag, ".en"},   32'(buffer_en),  32'(en));
        chk({tag, ".we"},   32'(buffer_we),  32'(we));
        chk({tag, ".addr"}, buffer_addr,     addr);
        chk({tag, ".din"},  buffer_din,      din);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue back-to-back scans and check each byte one cycle later
    task automatic scan_seq(input string tag, input logic [PAB-1:0] a [5], input logic [7:0] e [5]);
        for (int i = 0; i <= 5; i++) begin
            if (i > 0) begin
                chk({tag, ".rvalid"}, 32'(scan_rvalid), 32'h1);
                chk({tag, ".rdata"},  32'(scan_rdata),  32'(e[i-1]));
            end
            if (i < 5) begin
                scan_req        = 1'b1;
                scan_pixel_addr = a[i];
                #1;
                chk({tag, ".addr"}, buffer_addr, {a[i][31:2], 2'b00} & 32'h0001FFFC);
                chk({tag, ".we"},   32'(buffer_we), 32'h0);
            end else begin
                scan_req = 1'b0;
            end
            tick();
        end
        chk({tag, ".idle"}, 32'(scan_rvalid), 32'h0);
    endtask

    logic [PAB-1:0] sa [5];
    logic [7:0]     se [5];

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[0] = 32'hDDCCBBAA;
        mem[1] = 32'h00000011;
        buffer_dout     = 32'h0;
        reset           = 1'b1;
        scan_req        = 1'b0;
        scan_pixel_addr = '0;
        draw_valid      = 1'b0;
        draw_pixel_addr = '0;
        draw_color      = 8'h0;
        clear_start     = 1'b0;
        clear_color     = 8'h0;

        // ---- reset state
        tick(); tick();
        chk("rst.ready", 32'(draw_ready),  32'h0);
        chk("rst.busy",  32'(clear_busy),  32'h0);
        chk("rst.rvld",  32'(scan_rvalid), 32'h0);
        chk("rst.rdata", 32'(scan_rdata),  32'h0);
        chk("rst.en",    32'(buffer_en),   32'h0);
        chk("rst.brst",  32'(buffer_rst),  32'h0);
        reset = 1'b0;
        #1;
        chk("rst.ready_after", 32'(draw_ready), 32'h1);
        tick();

        // ---- scan only
        sa = '{17'd0, 17'd1, 17'd2, 17'd3, 17'd4};
        se = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11};
        scan_seq("scan", sa, se);

        // ---- single draw write
        draw_valid = 1'b1; draw_pixel_addr = 17'd6; draw_color = 8'h5A;
        #1;
        chk("draw.ready", 32'(draw_ready), 32'h1);
        tick();
        draw_valid = 1'b0;
        #1;
        port_chk("draw", 1'b1, 4'b0100, 32'h4, 32'h5A5A5A5A);
        chk("draw.ready2", 32'(draw_ready), 32'h1);
        tick();
        #1;
        port_chk("draw.done", 1'b0, 4'h0, 32'h0, 32'h0);

        // ---- FIFO fills while scan holds the port
        scan_req = 1'b1; scan_pixel_addr = 17'd0;
        for (int k = 0; k < 5; k++) begin
            draw_valid = 1'b1; draw_pixel_addr = PAB'(8 + k); draw_color = 8'(k + 1);
            #1;
            chk("full.ready", 32'(draw_ready), (k < 4) ? 32'h1 : 32'h0);
            tick();
        end
        draw_valid = 1'b0;
        scan_req   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            port_chk("full.pop", 1'b1, 4'(4'b0001 << k), 32'h8, {4{8'(k + 1)}});
            tick();
        end
        #1;
        port_chk("full.empty", 1'b0, 4'h0, 32'h0, 32'h0);
        chk("full.ready_back", 32'(draw_ready), 32'h1);

        // ---- clear with interleaved scans and a queued draw
        clear_color = 8'h07; clear_start = 1'b1;
        #1;
        chk("clr.busy0", 32'(clear_busy), 32'h0);
        tick();
        clear_start = 1'b0; clear_color = 8'hFF;
        draw_valid = 1'b1; draw_pixel_addr = 17'd13; draw_color = 8'h99;
        #1;
        chk("clr.busy1", 32'(clear_busy), 32'h1);
        port_chk("clr.w0", 1'b1, 4'hF, 32'h0, 32'h07070707);
        tick();
        draw_valid = 1'b0;
        #1;
        chk("clr.busy2", 32'(clear_busy), 32'h1);
        port_chk("clr.w1", 1'b1, 4'hF, 32'h4, 32'h07070707);
        tick();
        scan_req = 1'b1; scan_pixel_addr = 17'd5;
        #1;
        chk("clr.busy3", 32'(clear_busy), 32'h1);
        port_chk("clr.s0", 1'b1, 4'h0, 32'h4, 32'h0);
        tick();
        scan_pixel_addr = 17'd6;
        #1;
        chk("clr.busy4", 32'(clear_busy), 32'h1);
        chk("clr.s0data", 32'(scan_rdata), 32'h07);
        port_chk("clr.s1", 1'b1, 4'h0, 32'h4, 32'h0);
        tick();
        scan_req = 1'b0;
        #1;
        chk("clr.busy5", 32'(clear_busy), 32'h1);
        chk("clr.s1data", 32'(scan_rdata), 32'h07);
        port_chk("clr.w2", 1'b1, 4'hF, 32'h8, 32'h07070707);
        tick();
        #1;
        chk("clr.busy6", 32'(clear_busy), 32'h1);
        port_chk("clr.w3", 1'b1, 4'hF, 32'hC, 32'h07070707);
        tick();
        #1;
        chk("clr.busy_end", 32'(clear_busy), 32'h0);
        port_chk("clr.draw", 1'b1, 4'b0010, 32'hC, 32'h99999999);
        tick();
        #1;
        port_chk("clr.idle", 1'b0, 4'h0, 32'h0, 32'h0);

        // ---- reset in the middle of a clear
        clear_color = 8'h33; clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        draw_valid = 1'b1; draw_pixel_addr = 17'd20; draw_color = 8'hAA;
        #1;
        port_chk("rmc.w0", 1'b1, 4'hF, 32'h0, 32'h33333333);
        tick();
        draw_valid = 1'b0;
        #1;
        port_chk("rmc.w1", 1'b1, 4'hF, 32'h4, 32'h33333333);
        tick();
        #1;
        port_chk("rmc.w2", 1'b1, 4'hF, 32'h8, 32'h33333333);
        reset = 1'b1;
        tick();
        chk("rmc.busy",  32'(clear_busy), 32'h0);
        chk("rmc.en",    32'(buffer_en),  32'h0);
        chk("rmc.ready", 32'(draw_ready), 32'h0);
        reset = 1'b0;
        #1;
        chk("rmc.ready_after", 32'(draw_ready), 32'h1);
        chk("rmc.en_after",    32'(buffer_en),  32'h0);
        tick();
        chk("rmc.no_write", 32'(buffer_en), 32'h0);

        // Memory contents: word3 untouched by the aborted clear, draw discarded
        sa = '{17'd12, 17'd13, 17'd8, 17'd20, 17'd4};
        se = '{8'h07, 8'h99, 8'h33, 8'h00, 8'h33};
        scan_seq("rmc.mem", sa, se);

`ifdef FB_ARB_STATS_EN
        // ---- stall counter
        scan_req = 1'b1; scan_pixel_addr = 17'd0;
        for (int k = 0; k < 4; k++) begin
            draw_valid = 1'b1; draw_pixel_addr = PAB'(k); draw_color = 8'h01;
            tick();
        end
        for (int k = 0; k < 10; k++) tick();
        chk("stats.count", 32'(draw_stall_count), 32'd10);
        draw_valid = 1'b0; scan_req = 1'b0;
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        chk("stats.clear", 32'(draw_stall_count), 32'd0);
        for (int k = 0; k < 12; k++) tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so a stuck run still terminates with a report
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
- Shares the single 32-bit frame-buffer BRAM port between three requesters:
  - VGA scanout reads (highest priority, fixed latency).
  - A whole-buffer clear engine.
  - Pixel writes from the draw engine, absorbed by a small write FIFO.
- Pixels are 8-bit bytes packed four per word; pixel index bits [1:0] select the byte lane.
- Sits between the VGA timing/scanout logic and the BRAM controller port.

Parameters:
- PIXEL_ADDR_BITS, 17: width of pixel index (downscaled frame, 400x300 = 120000 pixels).
- NUM_PIXELS, 120000: pixel count; clear covers word indices 0..ceil(NUM_PIXELS/4)-1.
- READ_LATENCY, 1: BRAM read latency in clocks (1..3).
- WFIFO_DEPTH, 4: draw write FIFO entries (power of two, >=2).

Ports:
- clk, input, 1: single clock.
- reset, input, 1: synchronous, active-high.
- scan_req, input, 1: scanout read request this cycle.
- scan_pixel_addr, input, PIXEL_ADDR_BITS: pixel index to read.
- scan_rvalid, output, 1: scan_rdata valid.
- scan_rdata, output, 8: pixel byte read.
- draw_valid, input, 1: draw write offered.
- draw_ready, output, 1: FIFO can accept.
- draw_pixel_addr, input, PIXEL_ADDR_BITS: pixel index to write.
- draw_color, input, 8: pixel value.
- clear_start, input, 1: pulse; begin clear.
- clear_color, input, 8: fill value, sampled at clear_start.
- clear_busy, output, 1: clear in progress.
- buffer_addr, output, 32: byte address of word = {word_index, 2'b00}, zero-extended.
- buffer_din, output, 32: write data.
- buffer_dout, input, 32: read data.
- buffer_en, output, 1: port enable.
- buffer_rst, output, 1: tied 0.
- buffer_we, output, 4: byte write enables.

Behaviour:
- Reset: FIFO empty, draw_ready=0 while reset is high and 1 the cycle after; clear_busy=0; scan_rvalid=0; scan_rdata=0; read-tag pipeline cleared.
- Port outputs are combinational from the current grant. With no grant: buffer_en=0, buffer_we=0, buffer_addr=0, buffer_din=0.
- Grant priority each cycle: scan_req > clear engine (clear_busy) > FIFO head (non-empty). Exactly one grant per cycle.
- Scan grant:
  - buffer_addr = {scan_pixel_addr>>2, 2'b00}, buffer_en=1, buffer_we=0.
  - Lane scan_pixel_addr[1:0] is delayed READ_LATENCY cycles.
  - Request at cycle N gives scan_rvalid=1 at N+READ_LATENCY, with scan_rdata = buffer_dout[8*lane +: 8].
  - Back-to-back requests are fully pipelined.
- Clear engine:
  - States IDLE, CLEAR.
  - IDLE→CLEAR on clear_start: latch clear_color, word counter=0, clear_busy=1 the next cycle.
  - In CLEAR, each cycle without scan_req writes buffer_addr={counter,2'b00}, buffer_din={4{color}}, buffer_we=4'hF, then increments the counter.
  - After writing the last word, return to IDLE; clear_busy drops the following cycle.
  - Stalled cycles (scan_req high) do not advance the counter.
  - clear_start while busy is ignored.
- Draw FIFO:
  - Push when draw_valid && draw_ready; draw_ready = !full.
  - Pop when granted, i.e. no scan_req, not clear_busy, FIFO non-empty.
  - Write: buffer_addr={addr>>2,2'b00}, buffer_din={4{color}}, buffer_we = 4'b0001 << addr[1:0].
  - Push and pop in the same cycle are allowed (count unchanged). When full, draw_ready=0, so no push occurs.
  - FIFO is not drained during clear.
  - FIFO order is preserved. The scan read of a pixel whose write is still queued returns the old value; no forwarding.
- Reset mid-clear aborts immediately; the buffer is left partially cleared and queued draws are discarded.
- Out-of-range pixel indices are passed through unchecked.

Optional Feature:
- Macro: FB_ARB_STATS_EN.
- Defined: adds output draw_stall_count[15:0]. It increments each cycle with draw_valid && !draw_ready, saturates at 16'hFFFF, clears on reset and on clear_start.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Scan only: scan_req with addrs 0,1,2,3,4 and BRAM word0=32'hDDCCBBAA, word1=32'h00000011, READ_LATENCY=1 → scan_rvalid cycles N+1..N+5, scan_rdata AA,BB,CC,DD,11.
- Draw write: push addr 6, color 8'h5A with scan_req=0 → next cycle buffer_addr=32'h4, buffer_we=4'b0100, buffer_din=32'h5A5A5A5A; draw_ready stays 1.
- FIFO full under scan: scan_req held high, 5 draw pushes offered → 4 accepted, draw_ready=0 on the 5th. On scan_req low, 4 writes issue in order on consecutive cycles and draw_ready returns to 1.
- Clear with interleaved scan:
  - Setup: NUM_PIXELS=16, clear_color=8'h07; scan_req high for 2 cycles mid-clear.
  - Response: words 0..3 written with 32'h07070707 and we=4'hF.
  - clear_busy is high for 4+2 cycles; scans are served at their cycles.
  - A draw queued during the clear is written after clear_busy falls.
- Reset mid-clear: assert reset at word 2 → the next cycle clear_busy=0, buffer_en=0, and no further writes; draw_ready=1 the cycle after reset deasserts.
- With FB_ARB_STATS_EN: hold draw_valid against a full FIFO for 10 cycles → draw_stall_count=10; clear_start → 0.
